// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for the RV32I core. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) while this block drives the
// datapath control strobes, runs the req/ack handshakes to instruction and
// data memory, and counts retired instructions.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an undefined opcode seen in DECODE sends the FSM to FAULT.
//   undefined : an undefined opcode retires as a NOP straight from DECODE.
//
// Parameters
//   WAIT_LIMIT  cycles a memory request may wait without ack before FAULT
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk, rst         clock (rising edge), async active-high reset
//   opcode           instr[6:0] from the IR, valid from DECODE onward
//   branch_taken     ALU compare result, sampled in EXEC
//   imem_req/ack     instruction fetch handshake
//   dmem_req/we/ack  data access handshake (we=1 store, 0 load)
//   ir_load          IR load pulse
//   pc_write/pc_sel  PC update pulse and source (0 PC+4, 1 PC+imm, 2 rs1+imm)
//   alu_op/alu_src   ALU operation class and immediate-operand select
//   mem_read/write   load/store in progress
//   reg_write        register-file write pulse
//   jal/jalr         writeback selects PC+4 / JALR in flight
//   fault            sticky timeout (or illegal-opcode trap) flag
//   instret          retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             ir_load,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             jal,
   output logic             jalr,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_FAULT
   } state_t;

   typedef enum logic [2:0] {
      OP_ILL,
      OP_R,
      OP_I,
      OP_LOAD,
      OP_STORE,
      OP_BR,
      OP_JAL,
      OP_JALR
   } op_t;

   // The last cycle a request may go unanswered is the one where the counter
   // already holds WAIT_LIMIT-1; missing the ack there is the timeout.
   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t     state;
   state_t     state_next;
   op_t        op_q;
   op_t        op_dec;
   logic [7:0] wait_cnt;
   logic       retire;

   // Classify the live opcode; only consumed in DECODE, where it is latched.
   always_comb begin
      op_dec = OP_ILL;
      case (opcode)
         7'b0110011: op_dec = OP_R;
         7'b0010011: op_dec = OP_I;
         7'b0000011: op_dec = OP_LOAD;
         7'b0100011: op_dec = OP_STORE;
         7'b1100011: op_dec = OP_BR;
         7'b1101111: op_dec = OP_JAL;
         7'b1100111: op_dec = OP_JALR;
         default:    op_dec = OP_ILL;
      endcase
   end

   // State register plus the opcode class captured in DECODE so later
   // states are independent of whatever the IR bus does afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         op_q  <= OP_ILL;
      end else begin
         state <= state_next;
         if (state == S_DECODE)
            op_q <= op_dec;
      end
   end

   // Memory wait counter: restarts whenever the FSM changes state, so it is
   // zero on entry to FETCH or MEM, then counts every cycle spent waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (state_next != state)
         wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
         wait_cnt <= wait_cnt + 8'd1;
   end

   // Retired-instruction counter; wraps silently at the top of its range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         instret <= '0;
      else if (retire)
         instret <= instret + CNT_W'(1);
   end

   // Next-state and strobe decode. Reset forces every output low at once so
   // an in-flight request drops without waiting for a clock edge. The
   // branch decision lives entirely in the EXEC arm below.
   always_comb begin
      state_next = state;
      retire     = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'd0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      jal        = 1'b0;
      jalr       = 1'b0;
      fault      = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_load    = 1'b1;
                  state_next = S_DECODE;
               end else if (wait_cnt == LIMIT_M1) begin
                  state_next = S_FAULT;
               end
            end
            S_DECODE: begin
               if (op_dec == OP_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                  state_next = S_FAULT;
`else
                  pc_write   = 1'b1;
                  retire     = 1'b1;
                  state_next = S_FETCH;
`endif
               end else begin
                  state_next = S_EXEC;
               end
            end
            S_EXEC: begin
               case (op_q)
                  OP_R: begin
                     alu_op     = 2'b10;
                     state_next = S_WB;
                  end
                  OP_I, OP_JALR: begin
                     alu_src    = 1'b1;
                     state_next = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src    = 1'b1;
                     state_next = S_MEM;
                  end
                  OP_JAL: begin
                     state_next = S_WB;
                  end
                  OP_BR: begin
                     alu_op     = 2'b01;
                     pc_write   = 1'b1;
                     pc_sel     = branch_taken ? 2'd1 : 2'd0;
                     retire     = 1'b1;
                     state_next = S_FETCH;
                  end
                  default: begin
                     state_next = S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               dmem_req  = 1'b1;
               dmem_we   = (op_q == OP_STORE);
               mem_read  = (op_q == OP_LOAD);
               mem_write = (op_q == OP_STORE);
               if (dmem_ack) begin
                  if (op_q == OP_STORE) begin
                     pc_write   = 1'b1;
                     retire     = 1'b1;
                     state_next = S_FETCH;
                  end else begin
                     state_next = S_WB;
                  end
               end else if (wait_cnt == LIMIT_M1) begin
                  state_next = S_FAULT;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               jal        = (op_q == OP_JAL) || (op_q == OP_JALR);
               jalr       = (op_q == OP_JALR);
               pc_write   = 1'b1;
               pc_sel     = (op_q == OP_JAL)  ? 2'd1 :
                            (op_q == OP_JALR) ? 2'd2 : 2'd0;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            S_FAULT: begin
               fault = 1'b1;
            end
            default: begin
               state_next = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (WAIT_LIMIT=15, CNT_W=32). Inputs change
// 1 ns after each rising edge and outputs are sampled in the same window.
// Honors ILLEGAL_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ADDI  = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BAD   = 7'b0000000;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        imem_req;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        ir_load;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        jal;
   logic        jalr;
   logic        fault;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
      .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
      .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .jal(jal), .jalr(jalr),
      .fault(fault), .instret(instret)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock, then drive the next cycle's inputs.
   task automatic applyStimulus(input logic ia, input logic da, input logic bt,
                                input logic [6:0] op);
      @(posedge clk);
      #1;
      imem_ack     = ia;
      dmem_ack     = da;
      branch_taken = bt;
      opcode       = op;
      #1;
   endtask

   // In a FETCH cycle: ack the fetch at once, then move into DECODE.
   task automatic startInstr(input logic [6:0] op);
      imem_ack = 1'b1;
      opcode   = op;
      #1;
      checkOutput("fetch_ir_load", 32'(ir_load), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, op);
   endtask

   // Hold reset across an edge, check the reset state, release mid-cycle.
   task automatic doReset();
      rst          = 1'b1;
      imem_ack     = 1'b0;
      dmem_ack     = 1'b0;
      branch_taken = 1'b0;
      opcode       = OP_BAD;
      @(posedge clk);
      #1;
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_instret", instret, 32'd0);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      $display("[TB] start");
      doReset();

      // addi, zero-wait fetch: WB in cycle 4
      checkOutput("addi_imem_req_c1", 32'(imem_req), 32'd1);
      startInstr(OP_ADDI);
      checkOutput("addi_dec_imem_req", 32'(imem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      checkOutput("addi_alu_src", 32'(alu_src), 32'd1);
      checkOutput("addi_alu_op", 32'(alu_op), 32'd0);
      checkOutput("addi_exec_reg_write", 32'(reg_write), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      checkOutput("addi_reg_write", 32'(reg_write), 32'd1);
      checkOutput("addi_pc_write", 32'(pc_write), 32'd1);
      checkOutput("addi_pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("addi_jal", 32'(jal), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      checkOutput("addi_instret", instret, 32'd1);
      checkOutput("addi_next_imem_req", 32'(imem_req), 32'd1);

      // lw with three data-memory wait cycles (CPI 8)
      startInstr(OP_LW);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      checkOutput("lw_alu_src", 32'(alu_src), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
         checkOutput("lw_wait_dmem_req", 32'(dmem_req), 32'd1);
         checkOutput("lw_wait_dmem_we", 32'(dmem_we), 32'd0);
         checkOutput("lw_wait_mem_read", 32'(mem_read), 32'd1);
         checkOutput("lw_wait_reg_write", 32'(reg_write), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, OP_LW);
      checkOutput("lw_ack_dmem_req", 32'(dmem_req), 32'd1);
      checkOutput("lw_ack_pc_write", 32'(pc_write), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      checkOutput("lw_wb_reg_write", 32'(reg_write), 32'd1);
      checkOutput("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      checkOutput("lw_instret", instret, 32'd2);

      // beq taken, then not taken
      startInstr(OP_BEQ);
      applyStimulus(1'b0, 1'b0, 1'b1, OP_BEQ);
      checkOutput("beq_t_alu_op", 32'(alu_op), 32'd1);
      checkOutput("beq_t_pc_write", 32'(pc_write), 32'd1);
      checkOutput("beq_t_pc_sel", 32'(pc_sel), 32'd1);
      checkOutput("beq_t_reg_write", 32'(reg_write), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_BEQ);
      checkOutput("beq_t_instret", instret, 32'd3);
      startInstr(OP_BEQ);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_BEQ);
      checkOutput("beq_n_pc_write", 32'(pc_write), 32'd1);
      checkOutput("beq_n_pc_sel", 32'(pc_sel), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_BEQ);
      checkOutput("beq_n_instret", instret, 32'd4);
      checkOutput("beq_n_reg_write", 32'(reg_write), 32'd0);

      // jalr and jal writeback
      startInstr(OP_JALR);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JALR);
      checkOutput("jalr_alu_src", 32'(alu_src), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JALR);
      checkOutput("jalr_reg_write", 32'(reg_write), 32'd1);
      checkOutput("jalr_jal", 32'(jal), 32'd1);
      checkOutput("jalr_jalr", 32'(jalr), 32'd1);
      checkOutput("jalr_pc_sel", 32'(pc_sel), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JALR);
      checkOutput("jalr_instret", instret, 32'd5);
      startInstr(OP_JAL);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JAL);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JAL);
      checkOutput("jal_jal", 32'(jal), 32'd1);
      checkOutput("jal_jalr", 32'(jalr), 32'd0);
      checkOutput("jal_pc_sel", 32'(pc_sel), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_JAL);
      checkOutput("jal_instret", instret, 32'd6);

      // sw with zero-wait data memory retires from MEM
      startInstr(OP_SW);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_SW);
      applyStimulus(1'b0, 1'b1, 1'b0, OP_SW);
      checkOutput("sw_dmem_we", 32'(dmem_we), 32'd1);
      checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
      checkOutput("sw_mem_read", 32'(mem_read), 32'd0);
      checkOutput("sw_pc_write", 32'(pc_write), 32'd1);
      checkOutput("sw_reg_write", 32'(reg_write), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_SW);
      checkOutput("sw_instret", instret, 32'd7);
      checkOutput("sw_next_imem_req", 32'(imem_req), 32'd1);

      // R-type uses the funct-decoded ALU op
      startInstr(OP_RTYPE);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_RTYPE);
      checkOutput("r_alu_op", 32'(alu_op), 32'd2);
      checkOutput("r_alu_src", 32'(alu_src), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_RTYPE);
      checkOutput("r_reg_write", 32'(reg_write), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_RTYPE);
      checkOutput("r_instret", instret, 32'd8);

      // undefined opcode
      startInstr(OP_BAD);
`ifdef ILLEGAL_TRAP_EN
      applyStimulus(1'b0, 1'b0, 1'b0, OP_BAD);
      checkOutput("ill_fault", 32'(fault), 32'd1);
      checkOutput("ill_imem_req", 32'(imem_req), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, OP_ADDI);
      checkOutput("ill_fault_sticky", 32'(fault), 32'd1);
      checkOutput("ill_instret", instret, 32'd8);
`else
      checkOutput("nop_pc_write", 32'(pc_write), 32'd1);
      checkOutput("nop_pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("nop_reg_write", 32'(reg_write), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      checkOutput("nop_instret", instret, 32'd9);
      checkOutput("nop_imem_req", 32'(imem_req), 32'd1);
`endif

      // fetch timeout: 15 unanswered request cycles, then sticky FAULT
      doReset();
      for (int c = 1; c <= 15; c++) begin
         checkOutput("to_imem_req", 32'(imem_req), 32'd1);
         checkOutput("to_fault_low", 32'(fault), 32'd0);
         applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      end
      checkOutput("to_fault", 32'(fault), 32'd1);
      checkOutput("to_req_dropped", 32'(imem_req), 32'd0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, OP_ADDI);
         checkOutput("to_fault_sticky", 32'(fault), 32'd1);
         checkOutput("to_ir_load", 32'(ir_load), 32'd0);
      end
      checkOutput("to_instret_frozen", instret, 32'd0);

      // reset in the middle of a load's MEM wait
      doReset();
      startInstr(OP_ADDI);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADDI);
      checkOutput("mr_pre_instret", instret, 32'd1);
      startInstr(OP_LW);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      checkOutput("mr_dmem_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mr_dmem_req_drop", 32'(dmem_req), 32'd0);
      checkOutput("mr_mem_read", 32'(mem_read), 32'd0);
      checkOutput("mr_imem_req", 32'(imem_req), 32'd0);
      checkOutput("mr_instret", instret, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, OP_LW);
      checkOutput("mr_hold_reg_write", 32'(reg_write), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("mr_release_imem_req", 32'(imem_req), 32'd1);
      checkOutput("mr_release_dmem_req", 32'(dmem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LW);
      checkOutput("mr_release_instret", instret, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case something above stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
